// File: rtl/spongent_pkg.sv
// Shared types and per-variant lCounter constants for the Spongent permutation family.
// Constants are stored 16 bits wide and truncated to each variant's WIDTH at use.
package spongent_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rc_state_t;

    // Spongent-88
    localparam int          SP88_WIDTH   = 6;
    localparam logic [15:0] SP88_INIT    = 16'h0005;
    localparam logic [15:0] SP88_TAPS    = 16'h0030;
    localparam int          SP88_ROUNDS  = 45;

    // Spongent-128
    localparam int          SP128_WIDTH  = 7;
    localparam logic [15:0] SP128_INIT   = 16'h007A;
    localparam logic [15:0] SP128_TAPS   = 16'h0060;
    localparam int          SP128_ROUNDS = 70;

    // Spongent-160
    localparam int          SP160_WIDTH  = 7;
    localparam logic [15:0] SP160_INIT   = 16'h0045;
    localparam logic [15:0] SP160_TAPS   = 16'h0060;
    localparam int          SP160_ROUNDS = 90;

    // Spongent-224
    localparam int          SP224_WIDTH  = 8;
    localparam logic [15:0] SP224_INIT   = 16'h0001;
    localparam logic [15:0] SP224_TAPS   = 16'h008E;
    localparam int          SP224_ROUNDS = 120;

    // Spongent-256
    localparam int          SP256_WIDTH  = 8;
    localparam logic [15:0] SP256_INIT   = 16'h009E;
    localparam logic [15:0] SP256_TAPS   = 16'h008E;
    localparam int          SP256_ROUNDS = 140;

endpackage

// File: rtl/lcounter_next.sv
// Combinational one-step advance of the lCounter LFSR: shift left, feed back the
// parity of the tapped bits into bit 0.
module lcounter_next #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h8E
) (
    input  logic [WIDTH-1:0] lc,
    output logic [WIDTH-1:0] lc_next
);

    logic feedback;

    assign feedback = ^(lc & TAPS);
    assign lc_next  = {lc[WIDTH-2:0], feedback};

endmodule

// File: rtl/round_counter.sv
// Round sequencer for a Spongent permutation: emits the lCounter round constant,
// its bit-reversal, and the round index, and flags the last round and completion.
module round_counter
    import spongent_pkg::*;
#(
    parameter int               WIDTH  = SP256_WIDTH,
    parameter logic [WIDTH-1:0] INIT   = WIDTH'(SP256_INIT),
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(SP256_TAPS),
    parameter int               ROUNDS = SP256_ROUNDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          step,
    output logic [WIDTH-1:0]              lc,
    output logic [WIDTH-1:0]              lc_rev,
    output logic [$clog2(ROUNDS+1)-1:0]   round_idx,
    output logic                          busy,
    output logic                          last,
    output logic                          done
);

    localparam int IW = $clog2(ROUNDS + 1);

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("round_counter: WIDTH must be in 4..16");
    end
    if (INIT == '0) begin : g_bad_init
        $error("round_counter: INIT must be nonzero");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
        $error("round_counter: TAPS MSB must be set");
    end
    if (ROUNDS < 1 || ROUNDS > 65535) begin : g_bad_rounds
        $error("round_counter: ROUNDS must be in 1..65535");
    end

    rc_state_t        state_reg, state_next;
    logic [WIDTH-1:0] lc_reg, lc_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [WIDTH-1:0] lc_step;
    logic             at_last;

    lcounter_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .lc      (lc_reg),
        .lc_next (lc_step)
    );

    assign at_last = (idx_reg == IW'(ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            lc_reg    <= INIT;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            lc_reg    <= lc_next;
            idx_reg   <= idx_next;
        end
    end

    // start overrides whatever the current state is doing, including a pending step
    always_comb begin
        state_next = state_reg;
        lc_next    = lc_reg;
        idx_next   = idx_reg;
        if (start) begin
            state_next = ST_RUN;
            lc_next    = INIT;
            idx_next   = '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (step) begin
                        lc_next  = lc_step;
                        idx_next = idx_reg + 1'b1;
                        if (at_last) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign lc_rev[gi] = lc_reg[WIDTH-1-gi];
    end

    assign lc        = lc_reg;
    assign round_idx = idx_reg;
    assign busy      = (state_reg == ST_RUN);
    assign last      = (state_reg == ST_RUN) && at_last;
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_round_counter.sv
// Bench for round_counter: directed vector table, hand sequences for run/abort
// corners, and randomized traffic compared against an arithmetic reference model.
module tb_round_counter;

    localparam int R      = 140;
    localparam int IW     = $clog2(R + 1);
    localparam int M_INIT = 'h9E;
    localparam int M_TAPS = 'h8E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, step = 1'b0;
    logic [7:0]    lc, lc_rev;
    logic [IW-1:0] round_idx;
    logic          busy, last, done;

    logic       w7_start = 1'b0, w7_step = 1'b0;
    logic [6:0] w7_lc, w7_rev, w7_idx;
    logic       w7_busy, w7_last, w7_done;

    logic       r1_start = 1'b0, r1_step = 1'b0;
    logic [7:0] r1_lc, r1_rev;
    logic [0:0] r1_idx;
    logic       r1_busy, r1_last, r1_done;

    round_counter u_dut (
        .clk(clk), .rst(rst), .start(start), .step(step),
        .lc(lc), .lc_rev(lc_rev), .round_idx(round_idx),
        .busy(busy), .last(last), .done(done)
    );

    round_counter #(.WIDTH(7), .INIT(7'h7A), .TAPS(7'h60), .ROUNDS(70)) u_w7 (
        .clk(clk), .rst(rst), .start(w7_start), .step(w7_step),
        .lc(w7_lc), .lc_rev(w7_rev), .round_idx(w7_idx),
        .busy(w7_busy), .last(w7_last), .done(w7_done)
    );

    round_counter #(.WIDTH(8), .INIT(8'h9E), .TAPS(8'h8E), .ROUNDS(1)) u_r1 (
        .clk(clk), .rst(rst), .start(r1_start), .step(r1_step),
        .lc(r1_lc), .lc_rev(r1_rev), .round_idx(r1_idx),
        .busy(r1_busy), .last(r1_last), .done(r1_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integers and flags, advanced once per clock edge.
    int m_lc, m_idx;
    bit m_run, m_done;

    function automatic int m_next(input int v);
        return ((v << 1) | ($countones(v & M_TAPS) % 2)) % 256;
    endfunction

    function automatic int m_rev(input int v);
        int r = 0;
        for (int i = 0; i < 8; i++) r = r | (((v >> i) & 1) << (7 - i));
        return r;
    endfunction

    task automatic cycle();
        bit r_i = rst;
        bit s_i = start;
        bit t_i = step;
        @(posedge clk);
        #1;
        if (r_i) begin
            m_lc = M_INIT; m_idx = 0; m_run = 0; m_done = 0;
        end else if (s_i) begin
            m_lc = M_INIT; m_idx = 0; m_run = 1; m_done = 0;
        end else if (m_run && t_i) begin
            m_lc   = m_next(m_lc);
            m_idx  = m_idx + 1;
            m_done = (m_idx == R);
            m_run  = !m_done;
        end else begin
            m_done = 0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".lc"},     lc,        m_lc);
        check({tag, ".lc_rev"}, lc_rev,    m_rev(m_lc));
        check({tag, ".idx"},    round_idx, m_idx);
        check({tag, ".busy"},   busy,      m_run);
        check({tag, ".last"},   last,      m_run && (m_idx == R - 1));
        check({tag, ".done"},   done,      m_done);
    endtask

    typedef struct {
        bit         rst, start, step;
        logic [7:0] lc, rev;
        int         idx;
        bit         busy, last, done;
    } vec_t;

    vec_t tbl[8];
    int   last_cnt;

    initial begin
        tbl[0] = '{1, 0, 0, 8'h9E, 8'h79, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 8'h9E, 8'h79, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 1, 8'h9E, 8'h79, 0, 1, 0, 0};
        tbl[3] = '{0, 0, 1, 8'h3C, 8'h3C, 1, 1, 0, 0};
        tbl[4] = '{0, 0, 1, 8'h78, 8'h1E, 2, 1, 0, 0};
        tbl[5] = '{0, 0, 1, 8'hF1, 8'h8F, 3, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 8'hF1, 8'h8F, 3, 1, 0, 0};
        tbl[7] = '{0, 1, 0, 8'h9E, 8'h79, 0, 1, 0, 0};

        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; step = tbl[i].step;
            cycle();
            check($sformatf("vec%0d.lc", i),     lc,        tbl[i].lc);
            check($sformatf("vec%0d.lc_rev", i), lc_rev,    tbl[i].rev);
            check($sformatf("vec%0d.idx", i),    round_idx, tbl[i].idx);
            check($sformatf("vec%0d.busy", i),   busy,      tbl[i].busy);
            check($sformatf("vec%0d.last", i),   last,      tbl[i].last);
            check($sformatf("vec%0d.done", i),   done,      tbl[i].done);
        end
        rst = 0; start = 0; step = 0;

        // 7-bit variant
        w7_start = 1; cycle(); w7_start = 0;
        check("w7.start.lc", w7_lc, 7'h7A);
        w7_step = 1; cycle(); w7_step = 0;
        check("w7.step.lc",  w7_lc,  7'h74);
        check("w7.step.rev", w7_rev, 7'h17);
        check("w7.step.idx", w7_idx, 1);

        // single-round variant
        r1_start = 1; cycle(); r1_start = 0;
        check("r1.busy", r1_busy, 1);
        check("r1.last", r1_last, 1);
        r1_step = 1; cycle(); r1_step = 0;
        check("r1.done",     r1_done, 1);
        check("r1.busy_off", r1_busy, 0);
        check("r1.idx",      r1_idx,  1);
        cycle();
        check("r1.done_end", r1_done, 0);

        // full 140-round run
        start = 1; cycle(); start = 0;
        check_model("full.start");
        last_cnt = 0;
        step = 1;
        for (int k = 0; k < R; k++) begin
            if (last) last_cnt++;
            if (k == R - 1) check("full.last_at_139", last, 1);
            cycle();
            check_model("full.step");
        end
        step = 0;
        check("full.last_count", last_cnt, 1);
        check("full.done",       done,      1);
        check("full.busy",       busy,      0);
        check("full.idx",        round_idx, R);
        cycle();
        check("full.done_end", done,      0);
        check("full.busy_end", busy,      0);
        check("full.idx_hold", round_idx, R);
        step = 1; cycle(); step = 0;
        check_model("full.idle_step");

        // reset at round 50, with step held to exercise reset priority
        start = 1; cycle(); start = 0;
        step = 1;
        for (int k = 0; k < 50; k++) cycle();
        check("abort.idx50", round_idx, 50);
        rst = 1; start = 1; cycle(); rst = 0; start = 0;
        check("abort.lc",     lc,        8'h9E);
        check("abort.lc_rev", lc_rev,    8'h79);
        check("abort.idx",    round_idx, 0);
        check("abort.busy",   busy,      0);
        check("abort.done",   done,      0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("abort.no_done", done, 0);
            check_model("abort.idle");
        end
        step = 0;

        // restart at round 20, start and step together
        start = 1; cycle(); start = 0;
        step = 1;
        for (int k = 0; k < 20; k++) cycle();
        check("restart.idx20", round_idx, 20);
        start = 1; cycle(); start = 0; step = 0;
        check("restart.lc",   lc,        8'h9E);
        check("restart.idx",  round_idx, 0);
        check("restart.busy", busy,      1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 249) == 0);
            start = ($urandom_range(0, 299) == 0);
            step  = ($urandom_range(0, 3) != 0);
            cycle();
            check_model("rand");
        end
        rst = 0; start = 0; step = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
